// File: rtl/prv32_div_unit_pkg.sv
// rtl/prv32_div_unit_pkg.sv - shared ALU function codes, divider state encoding and decode helpers
//
// Purpose: the divide-class alufn codes are also used by the prv32_ALU decode, so they live here
//          next to the divider FSM state type and the small decode functions built on them.
// Contents:
//   ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU  5-bit alufn codes
//   div_state_e                              2-bit divider FSM state
//   is_div(alufn)                            any of the four divide-class ops
//   is_signed_div(alufn)                     DIV or REM
//   is_rem_op(alufn)                         REM or REMU (result is the remainder)
package prv32_div_unit_pkg;

  localparam logic [4:0] ALU_DIV  = 5'b11100;
  localparam logic [4:0] ALU_DIVU = 5'b01100;
  localparam logic [4:0] ALU_REM  = 5'b00100;
  localparam logic [4:0] ALU_REMU = 5'b11000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  function automatic logic is_div(input logic [4:0] fn);
    return (fn == ALU_DIV) || (fn == ALU_DIVU) || (fn == ALU_REM) || (fn == ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] fn);
    return (fn == ALU_DIV) || (fn == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] fn);
    return (fn == ALU_REM) || (fn == ALU_REMU);
  endfunction

endpackage

// File: rtl/prv32_div_unit.sv
// rtl/prv32_div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Purpose: sits beside prv32_ALU in EX. Operands are captured from ID/EX, the pipeline is held
//          through stall while one quotient bit is produced per cycle, and the registered result
//          is presented with a one-cycle done pulse for the EX result mux.
// Ports:
//   clk    in   1     rising-edge clock
//   rst    in   1     synchronous active-high reset
//   start  in   1     EX holds a divide-class op (only looked at in IDLE)
//   flush  in   1     synchronous abort of the op in EX
//   alufn  in   5     ALU function code
//   a      in   XLEN  dividend (rs1)
//   b      in   XLEN  divisor (rs2)
//   stall  out  1     combinational pipeline hold
//   busy   out  1     registered, high in CALC/FIX
//   done   out  1     registered, one-cycle pulse with r valid
//   r      out  XLEN  registered quotient or remainder
module prv32_div_unit
  import prv32_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alufn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  div_state_e        r_state;
  div_state_e        w_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_bmag;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_sel_rem;
  logic [XLEN-1:0]   r_result;
  logic              r_done;
  logic              r_busy;

  logic              w_is_div;
  logic              w_signed;
  logic              w_rem_op;
  logic              w_accept;
  logic              w_b_zero;
  logic              w_overflow;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic              w_trial_ok;
  logic              w_last_step;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;

  // ---------------- operand decode ----------------
  assign w_is_div   = is_div(alufn);
  assign w_signed   = is_signed_div(alufn);
  assign w_rem_op   = is_rem_op(alufn);
  assign w_accept   = start & w_is_div & ~flush;

  assign w_b_zero   = (b == '0);
  assign w_overflow = w_signed & (a == SMIN) & (b == ONES);
  assign w_special  = w_b_zero | w_overflow;

  // Division by zero returns the raw dividend as remainder; signed overflow returns SMIN / 0.
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = w_rem_op ? a : ONES;
    end else begin
      w_special_res = w_rem_op ? '0 : SMIN;
    end
  end

  // Negating 0x8000_0000 wraps back to itself, which is exactly its unsigned magnitude.
  assign w_a_mag = (w_signed & a[XLEN-1]) ? (~a + 1'b1) : a;
  assign w_b_mag = (w_signed & b[XLEN-1]) ? (~b + 1'b1) : b;

  // ---------------- restoring step ----------------
  // The partial remainder is always below |b|, so after the shift it fits in XLEN+1 bits and
  // the top bit of the XLEN+1-bit difference is a reliable borrow flag.
  assign w_shift     = {r_rem, r_quo[XLEN-1]};
  assign w_trial     = w_shift - {1'b0, r_bmag};
  assign w_trial_ok  = ~w_trial[XLEN];
  assign w_last_step = (r_cnt == CNT_W'(XLEN-1));

  assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = start & w_is_div;
        if (w_accept) begin
          w_next = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stall = 1'b1;
        if (flush) begin
          w_next = S_IDLE;
        end else if (w_last_step) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        stall  = 1'b1;
        w_next = flush ? S_IDLE : S_DONE;
      end
      default: begin
        // DONE: stall drops so the pipeline advances and EX/MEM captures r on this edge.
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_bmag    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= (w_next == S_DONE);
      r_busy <= (w_next == S_CALC) || (w_next == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_bmag    <= w_b_mag;
            r_neg_q   <= w_signed & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_r   <= w_signed & a[XLEN-1];
            r_sel_rem <= w_rem_op;
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_rem <= w_trial_ok ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_trial_ok};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_result <= r_sel_rem ? w_r_fix : w_q_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign r    = r_result;

endmodule

// File: tb/tb_prv32_div_unit.sv
// tb/tb_prv32_div_unit.sv - directed self-checking bench for prv32_div_unit
module tb_prv32_div_unit;

  localparam logic [4:0] F_DIV  = 5'b11100;
  localparam logic [4:0] F_DIVU = 5'b01100;
  localparam logic [4:0] F_REM  = 5'b00100;
  localparam logic [4:0] F_REMU = 5'b11000;
  localparam logic [4:0] F_ADD  = 5'b00000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [4:0]  alufn;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int vecs;
  int errs;

  prv32_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .alufn (alufn),
    .a     (a),
    .b     (b),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .r     (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a new op in the cycle that follows the next rising edge (that cycle is cycle 0).
  task automatic launch(input logic [4:0] fn, input logic [31:0] va, input logic [31:0] vb);
    @(posedge clk);
    #1;
    start = 1'b1;
    alufn = fn;
    a     = va;
    b     = vb;
  endtask

  // Measure from cycle 0: returns the cycle done was seen (-1 on timeout), number of
  // stall-high cycles and the last stall-high cycle. Returns at the sample point of the done cycle.
  task automatic wait_done(input bit hold, output int done_cyc, output int st_cnt, output int st_last);
    int cyc;
    cyc      = 0;
    done_cyc = -1;
    st_cnt   = 0;
    st_last  = -1;
    while (cyc <= 60) begin
      #1;
      if (stall === 1'b1) begin
        st_cnt++;
        st_last = cyc;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; alufn = F_ADD; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({stall, busy, done} !== 3'b000 || res !== 32'h0) begin
      $display("FAIL reset: stall/busy/done=%b r=%h required 000 / 00000000", {stall, busy, done}, res);
      errs++;
    end
    rst = 1'b0;
  endtask

  task automatic test_divu();
    int dc, sc, sl;
    launch(F_DIVU, 32'd100, 32'd7);
    wait_done(1'b0, dc, sc, sl);
    vecs++;
    if (dc !== 34) begin $display("FAIL divu_latency: done cycle %0d required 34", dc); errs++; end
    vecs++;
    if (sc !== 34 || sl !== 33) begin
      $display("FAIL divu_stall: %0d cycles last %0d required 34 last 33", sc, sl); errs++;
    end
    vecs++;
    if (res !== 32'd14) begin $display("FAIL divu_result: r=%h required 0000000e", res); errs++; end
    @(posedge clk);
    #2;
    vecs++;
    if ({stall, busy, done} !== 3'b000 || res !== 32'd14) begin
      $display("FAIL divu_idle: stall/busy/done=%b r=%h required 000 / 0000000e", {stall, busy, done}, res);
      errs++;
    end
  endtask

  typedef struct packed {
    logic [4:0]  fn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp;
  } vec_t;

  task automatic test_signed();
    vec_t tbl [6];
    int dc, sc, sl;
    tbl[0] = '{F_REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    tbl[1] = '{F_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    tbl[2] = '{F_REMU, 32'd100,       32'd7,          32'd2};
    tbl[3] = '{F_DIV,  32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2};
    tbl[4] = '{F_REM,  32'd100,       32'hFFFF_FFF9,  32'd2};
    tbl[5] = '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0};
    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].fn, tbl[i].va, tbl[i].vb);
      wait_done(1'b0, dc, sc, sl);
      vecs++;
      if (dc !== 34 || res !== tbl[i].exp) begin
        $display("FAIL signed[%0d]: done cycle %0d r=%h required 34 / %h", i, dc, res, tbl[i].exp);
        errs++;
      end
    end
  endtask

  task automatic test_div_by_zero();
    int dc, sc, sl;
    launch(F_DIV, 32'd5, 32'd0);
    wait_done(1'b0, dc, sc, sl);
    vecs++;
    if (dc !== 1 || sc !== 1 || sl !== 0 || res !== 32'hFFFF_FFFF) begin
      $display("FAIL div_zero: done %0d stall %0d/%0d r=%h required 1, 1/0, ffffffff", dc, sc, sl, res);
      errs++;
    end
    launch(F_REMU, 32'd5, 32'd0);
    wait_done(1'b0, dc, sc, sl);
    vecs++;
    if (dc !== 1 || res !== 32'd5) begin
      $display("FAIL remu_zero: done %0d r=%h required 1 / 00000005", dc, res);
      errs++;
    end
  endtask

  task automatic test_overflow();
    int dc, sc, sl;
    launch(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, dc, sc, sl);
    vecs++;
    if (dc !== 1 || sc !== 1 || res !== 32'h8000_0000) begin
      $display("FAIL div_ovf: done %0d stall %0d r=%h required 1, 1, 80000000", dc, sc, res);
      errs++;
    end
    launch(F_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, dc, sc, sl);
    vecs++;
    if (dc !== 1 || res !== 32'h0) begin
      $display("FAIL rem_ovf: done %0d r=%h required 1 / 00000000", dc, res);
      errs++;
    end
  endtask

  task automatic test_flush();
    int  dc, sc, sl;
    bit  saw_done;
    launch(F_REMU, 32'd5, 32'd0);
    wait_done(1'b0, dc, sc, sl);
    launch(F_DIVU, 32'hFFFF_FFFF, 32'd1);
    saw_done = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (cyc == 10) flush = 1'b1;
      #1;
      if (done === 1'b1) saw_done = 1;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    vecs++;
    if (saw_done || {stall, busy, done} !== 3'b000 || res !== 32'd5) begin
      $display("FAIL flush: early done %0d stall/busy/done=%b r=%h required 0, 000 / 00000005",
               saw_done, {stall, busy, done}, res);
      errs++;
    end
    start = 1'b1;
    alufn = F_DIVU;
    a     = 32'hFFFF_FFFF;
    b     = 32'd1;
    wait_done(1'b0, dc, sc, sl);
    vecs++;
    if (dc !== 34 || sc !== 34 || res !== 32'hFFFF_FFFF) begin
      $display("FAIL flush_restart: done %0d stall %0d r=%h required 34, 34, ffffffff", dc, sc, res);
      errs++;
    end
  endtask

  task automatic test_back_to_back();
    int dc, sc, sl;
    int bad;
    launch(F_DIV, 32'd5, 32'd0);
    wait_done(1'b1, dc, sc, sl);
    alufn = F_ADD;
    #1;
    vecs++;
    if (dc !== 1 || stall !== 1'b0) begin
      $display("FAIL hold_done: done %0d stall %b required 1 / 0", dc, stall);
      errs++;
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      if ({stall, busy, done} !== 3'b000 || res !== 32'hFFFF_FFFF) bad++;
    end
    vecs++;
    if (bad != 0) begin
      $display("FAIL add_ignored: %0d bad cycles required 0", bad);
      errs++;
    end
    start = 1'b0;
  endtask

  task automatic test_rst_mid();
    int dc, sc, sl;
    bit saw_done;
    launch(F_DIV, 32'd100, 32'd7);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (cyc == 20) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vecs++;
    if ({stall, busy, done} !== 3'b000 || res !== 32'h0) begin
      $display("FAIL rst_mid: stall/busy/done=%b r=%h required 000 / 00000000", {stall, busy, done}, res);
      errs++;
    end
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    vecs++;
    if (saw_done) begin
      $display("FAIL rst_no_done: activity after reset %0d required 0", saw_done);
      errs++;
    end
    dc = 0; sc = 0; sl = 0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_divu();
    test_signed();
    test_div_by_zero();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
